// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - JK drive codes and parameter legality check for jk_mod_counter
package jk_counter_pkg;

  // {j,k} pairs: hold=00, clear=01, set=10, toggle=11
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_code_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 16;
  localparam int MODULUS_MIN = 2;

  function automatic bit params_ok(input int width, input int modulus);
    if (width < WIDTH_MIN || width > WIDTH_MAX) return 1'b0;
    if (modulus < MODULUS_MIN) return 1'b0;
    if (modulus > (1 << width)) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-low reset
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic q_n
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign q_n = ~q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo up/down counter built from JK cells, with clear, clamped load and wrap pulse
module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             carry
);

  if (!params_ok(WIDTH, MODULUS)) begin : g_param_check
    $error("jk_mod_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
  end

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] target;
  logic             wrap;
  jk_code_t         code [WIDTH];

  always_comb begin
    target = q;
    wrap   = 1'b0;
    if (clr) begin
      target = '0;
    end else if (load) begin
      target = (32'(load_val) >= 32'(MODULUS)) ? Q_MAX : load_val;
    end else if (en) begin
      if (up) begin
        if (q == Q_MAX) begin
          target = '0;
          wrap   = 1'b1;
        end else begin
          target = q + WIDTH'(1);
        end
      end else begin
        if (q == '0) begin
          target = Q_MAX;
          wrap   = 1'b1;
        end else begin
          target = q - WIDTH'(1);
        end
      end
    end
  end

  // Clear/load force every bit explicitly; counting only toggles the bits that change.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      code[i] = JK_HOLD;
      if (clr || load) begin
        code[i] = target[i] ? JK_SET : JK_CLR;
      end else if (target[i] ^ q[i]) begin
        code[i] = JK_TGL;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .j     (code[g][1]),
      .k     (code[g][0]),
      .q     (q[g]),
      .q_n   (q_n[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry <= 1'b0;
    end else begin
      carry <= wrap;
    end
  end

endmodule
